cook_sequencer: RTL and testbench

- Cycle-level controller for the microwave cook cycle.
- Accepts keypad time entry as four BCD digits (MM:SS) and counts the time down once per second.
- Sequences the magnetron enable from the start/stop/clear buttons and the door sensor, and produces the end-of-cook pulse and beeper.
- Sits between the front-panel inputs and the magnetron drive; it is the clocked replacement for the set/reset magnetron latch path.

---
 rtl/cook_sequencer_if.sv | 25 ++
 rtl/cook_sequencer.sv | 97 +++++++++
 tb/tb_cook_sequencer.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/cook_sequencer_if.sv
// cook_sequencer_if: front-panel inputs and magnetron/display outputs of the cook sequencer
interface cook_sequencer_if;
  logic       startn;
  logic       stopn;
  logic       clearn;
  logic       door_closed;
  logic       key_valid;
  logic [3:0] key_digit;
  logic       mag_on;
  logic [3:0] min_tens;
  logic [3:0] min_ones;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic [1:0] state;
  logic       timer_done;
  logic       beep;
  modport master (
    output startn, stopn, clearn, door_closed, key_valid, key_digit,
    input  mag_on, min_tens, min_ones, sec_tens, sec_ones, state, timer_done, beep
  );
  modport slave (
    input  startn, stopn, clearn, door_closed, key_valid, key_digit,
    output mag_on, min_tens, min_ones, sec_tens, sec_ones, state, timer_done, beep
  );
endinterface

// File: rtl/cook_sequencer.sv
// cook_sequencer: microwave cook-cycle controller with BCD MM:SS countdown and magnetron sequencing
module cook_sequencer #(
  parameter int TICKS_PER_SEC = 100,
  parameter int BEEP_SECS     = 3
) (
  input logic              clk,
  input logic              resetn,
  cook_sequencer_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, COOK, PAUSE, DONE} state_t;
  localparam int PW = $clog2(TICKS_PER_SEC);
  localparam int BW = $clog2(BEEP_SECS + 1);
  state_t        fsm;
  logic [15:0]   tm;
  logic [PW-1:0] pre;
  logic [BW-1:0] bcnt;
  logic [2:0]    prev;
  logic          timer_done, beep;
  logic          sp, pp, cp, tick, so_z, st_z, mo_z, dec_zero;
  logic [15:0]   dec;
  always_comb begin
    sp       = prev[2] & ~bus.startn;
    pp       = prev[1] & ~bus.stopn;
    cp       = prev[0] & ~bus.clearn;
    tick     = pre == PW'(TICKS_PER_SEC - 1);
    so_z     = tm[3:0] == 4'd0;
    st_z     = tm[7:4] == 4'd0;
    mo_z     = tm[11:8] == 4'd0;
    dec[3:0]   = so_z ? 4'd9 : tm[3:0] - 4'd1;
    dec[7:4]   = so_z ? (st_z ? 4'd5 : tm[7:4] - 4'd1) : tm[7:4];
    dec[11:8]  = (so_z & st_z) ? (mo_z ? 4'd9 : tm[11:8] - 4'd1) : tm[11:8];
    dec[15:12] = (so_z & st_z & mo_z) ? tm[15:12] - 4'd1 : tm[15:12];
    dec_zero = dec == 16'd0;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fsm        <= IDLE;
      tm         <= '0;
      pre        <= '0;
      bcnt       <= '0;
      prev       <= 3'b111;
      timer_done <= 1'b0;
      beep       <= 1'b0;
    end else begin
      timer_done <= 1'b0;
      prev       <= {bus.startn, bus.stopn, bus.clearn};
      case (fsm)
        IDLE:
          if (cp | pp) tm <= '0;
          else if (sp && bus.door_closed && tm != 16'd0) begin
            fsm <= COOK;
            pre <= '0;
          end else if (bus.key_valid && bus.key_digit <= 4'd9) tm <= {tm[11:0], bus.key_digit};
        COOK:
          if (cp) begin
            fsm <= IDLE;
            tm  <= '0;
          end else if (pp | ~bus.door_closed) fsm <= PAUSE;
          else if (tick) begin
            pre <= '0;
            tm  <= dec;
            if (dec_zero) begin
              fsm        <= DONE;
              timer_done <= 1'b1;
              beep       <= 1'b1;
              bcnt       <= '0;
            end
          end else pre <= pre + 1'b1;
        PAUSE:
          if (pp | cp) begin
            fsm <= IDLE;
            tm  <= '0;
          end else if (sp && bus.door_closed) fsm <= COOK;
        DONE:
          if (sp | pp | cp | bus.key_valid) begin
            fsm  <= IDLE;
            beep <= 1'b0;
            pre  <= '0;
          end else if (tick) begin
            pre <= '0;
            if (bcnt == BW'(BEEP_SECS - 1)) begin
              fsm  <= IDLE;
              beep <= 1'b0;
            end else bcnt <= bcnt + 1'b1;
          end else pre <= pre + 1'b1;
      endcase
    end
  end
  assign bus.mag_on     = (fsm == COOK) & bus.door_closed;
  assign bus.state      = fsm;
  assign bus.min_tens   = tm[15:12];
  assign bus.min_ones   = tm[11:8];
  assign bus.sec_tens   = tm[7:4];
  assign bus.sec_ones   = tm[3:0];
  assign bus.timer_done = timer_done;
  assign bus.beep       = beep;
endmodule

// File: tb/tb_cook_sequencer.sv
// tb_cook_sequencer: directed scenarios with a snapshot scoreboard for cook_sequencer
module tb_cook_sequencer;
  localparam int TPS = 4;
  localparam int BS  = 3;
  localparam logic [1:0] IDLE = 2'd0, COOK = 2'd1, PAUSE = 2'd2, DONE = 2'd3;
  logic clk, resetn;
  int tests, fails;
  logic [20:0] exp_q[$];
  string tag_q[$];
  cook_sequencer_if bus();
  cook_sequencer #(.TICKS_PER_SEC(TPS), .BEEP_SECS(BS)) dut (.clk(clk), .resetn(resetn), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
  function automatic logic [20:0] snap();
    return {bus.mag_on, bus.timer_done, bus.beep, bus.state,
            bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones};
  endfunction
  function automatic logic [20:0] mk(logic m, logic td, logic bp, logic [1:0] s, logic [15:0] t);
    return {m, td, bp, s, t};
  endfunction
  task automatic observe();
    logic [20:0] e, a;
    string t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    a = snap();
    tests++;
    assert (a === e) else begin
      fails++;
      $error("FAIL %s: observed {mag,td,beep,state,time}=%h expected %h", t, a, e);
    end
  endtask
  task automatic chk(string t, logic [20:0] e);
    exp_q.push_back(e);
    tag_q.push_back(t);
    observe();
  endtask
  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic key(logic [3:0] d);
    bus.key_valid = 1'b1;
    bus.key_digit = d;
    step(1);
    bus.key_valid = 1'b0;
  endtask
  task automatic press(logic s, logic p, logic c);
    bus.startn = ~s;
    bus.stopn  = ~p;
    bus.clearn = ~c;
    step(1);
    bus.startn = 1'b1;
    bus.stopn  = 1'b1;
    bus.clearn = 1'b1;
  endtask
  initial begin
    tests = 0;
    fails = 0;
    resetn = 1'b0;
    bus.startn = 1'b1;
    bus.stopn = 1'b1;
    bus.clearn = 1'b1;
    bus.door_closed = 1'b1;
    bus.key_valid = 1'b0;
    bus.key_digit = 4'd0;
    #1;
    chk("reset", mk(0, 0, 0, IDLE, 16'h0000));
    #12 resetn = 1'b1;
    step(1);
    key(4'd1); chk("key1", mk(0, 0, 0, IDLE, 16'h0001));
    key(4'd3); chk("key3", mk(0, 0, 0, IDLE, 16'h0013));
    key(4'd0); chk("key0", mk(0, 0, 0, IDLE, 16'h0130));
    key(4'd12); chk("key12_ignored", mk(0, 0, 0, IDLE, 16'h0130));
    key(4'd5); chk("key5_shift", mk(0, 0, 0, IDLE, 16'h1305));
    press(0, 0, 1); chk("clear_idle", mk(0, 0, 0, IDLE, 16'h0000));
    key(4'd3);
    press(1, 0, 0); chk("start_cook", mk(1, 0, 0, COOK, 16'h0003));
    step(3); chk("pre_tick", mk(1, 0, 0, COOK, 16'h0003));
    step(1); chk("tick1", mk(1, 0, 0, COOK, 16'h0002));
    step(4); chk("tick2", mk(1, 0, 0, COOK, 16'h0001));
    step(3); chk("pre_tick3", mk(1, 0, 0, COOK, 16'h0001));
    step(1); chk("done_entry", mk(0, 1, 1, DONE, 16'h0000));
    step(1); chk("done_pulse_end", mk(0, 0, 1, DONE, 16'h0000));
    step(10); chk("beep_last", mk(0, 0, 1, DONE, 16'h0000));
    step(1); chk("beep_end", mk(0, 0, 0, IDLE, 16'h0000));
    key(4'd1); key(4'd0); key(4'd0);
    press(1, 0, 0);
    step(4); chk("borrow_0100", mk(1, 0, 0, COOK, 16'h0059));
    press(0, 0, 1); chk("clear_cook", mk(0, 0, 0, IDLE, 16'h0000));
    key(4'd1); key(4'd0); key(4'd0); key(4'd0);
    press(1, 0, 0);
    step(4); chk("borrow_1000", mk(1, 0, 0, COOK, 16'h0959));
    press(0, 0, 1);
    key(4'd1); key(4'd0);
    press(1, 0, 0);
    step(2);
    bus.door_closed = 1'b0;
    #1; chk("door_open_comb", mk(0, 0, 0, COOK, 16'h0010));
    step(1); chk("door_pause", mk(0, 0, 0, PAUSE, 16'h0010));
    press(1, 0, 0); chk("start_door_open", mk(0, 0, 0, PAUSE, 16'h0010));
    bus.door_closed = 1'b1;
    step(5); chk("pause_hold", mk(0, 0, 0, PAUSE, 16'h0010));
    press(1, 0, 0); chk("resume", mk(1, 0, 0, COOK, 16'h0010));
    step(1); chk("resume_pre_kept", mk(1, 0, 0, COOK, 16'h0010));
    step(1); chk("resume_tick", mk(1, 0, 0, COOK, 16'h0009));
    press(1, 1, 1); chk("all_buttons", mk(0, 0, 0, IDLE, 16'h0000));
    key(4'd5);
    bus.door_closed = 1'b0;
    press(1, 0, 0); chk("idle_start_door_open", mk(0, 0, 0, IDLE, 16'h0005));
    bus.door_closed = 1'b1;
    press(0, 0, 1);
    press(1, 0, 0); chk("idle_start_zero", mk(0, 0, 0, IDLE, 16'h0000));
    key(4'd9);
    press(1, 0, 0);
    press(0, 1, 0); chk("stop_pause", mk(0, 0, 0, PAUSE, 16'h0009));
    bus.startn = 1'b0;
    step(10); chk("held_resume", mk(1, 0, 0, COOK, 16'h0007));
    bus.stopn = 1'b0;
    step(1);
    bus.stopn = 1'b1;
    step(9); chk("held_no_repeat", mk(0, 0, 0, PAUSE, 16'h0007));
    bus.startn = 1'b1;
    step(1); chk("release_start", mk(0, 0, 0, PAUSE, 16'h0007));
    press(0, 1, 0); chk("stop_in_pause", mk(0, 0, 0, IDLE, 16'h0000));
    key(4'd5);
    press(1, 0, 0);
    step(1);
    resetn = 1'b0;
    #1; chk("async_reset", mk(0, 0, 0, IDLE, 16'h0000));
    #2 resetn = 1'b1;
    step(1); chk("after_reset", mk(0, 0, 0, IDLE, 16'h0000));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
